// File: rtl/uart8_rx_fifo.sv
// uart8_rx_fifo: 8N1 UART receiver with a show-ahead receive FIFO.
// The serial line is synchronised and oversampled at 16x the bit rate.
// A start bit is confirmed at mid-bit. Data bits are sampled LSB first,
// one bit period apart. Good frames are pushed into the FIFO. A frame
// whose stop bit is low raises a one-cycle rxErr and is dropped. When
// a byte arrives while the FIFO is full, the byte is dropped and the
// sticky overflow flag is set.
module uart8_rx_fifo #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rxEn,
  input  logic                               rxIn,
  output logic                               rxBusy,
  output logic                               rxErr,
  input  logic                               rdEn,
  output logic [7:0]                         rdData,
  output logic                               empty,
  output logic                               full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  input  logic                               clrErr,
  output logic                               overflow
);

  // Oversample divider. A divisor that rounds to zero is clamped to one,
  // so the tick still advances.
  localparam int TICK_DIV_RAW = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
  localparam int DIV_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rxState_t;

  // Line synchroniser
  logic syncMeta_r;
  logic syncLine_r;

  // Receiver state
  rxState_t         state_r;
  rxState_t         stateNext_s;
  logic [DIV_W-1:0] divCnt_r;
  logic [DIV_W-1:0] divCntNext_s;
  logic [3:0]       tickCnt_r;
  logic [3:0]       tickCntNext_s;
  logic [2:0]       bitCnt_r;
  logic [2:0]       bitCntNext_s;
  logic [7:0]       shift_r;
  logic [7:0]       shiftNext_s;
  logic             tick_s;
  logic             pushReq_s;
  logic             frameErr_s;
  logic             rxBusy_r;
  logic             rxErr_r;

  // FIFO state
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W-1:0] rdPtr_r;
  logic [PTR_W-1:0] wrPtrNext_s;
  logic [PTR_W-1:0] rdPtrNext_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] countNext_s;
  logic             empty_r;
  logic             full_r;
  logic             overflow_r;
  logic             overflowNext_s;
  logic [7:0]       rdData_r;
  logic [7:0]       rdDataNext_s;
  logic             doPop_s;
  logic             doPush_s;
  logic             ovfEvent_s;

  // Two-flop synchroniser for the asynchronous line. It resets to the idle (high) level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncMeta_r <= 1'b1;
      syncLine_r <= 1'b1;
    end else begin
      syncMeta_r <= rxIn;
      syncLine_r <= syncMeta_r;
    end
  end

  // The oversample tick fires on the last count of the divider period.
  assign tick_s = (divCnt_r == DIV_LAST);

  // Receiver next-state logic: frame sequencing, bit sampling and the push/error strobes.
  always_comb begin
    stateNext_s   = state_r;
    divCntNext_s  = tick_s ? '0 : (divCnt_r + DIV_W'(1));
    tickCntNext_s = tick_s ? (tickCnt_r + 4'd1) : tickCnt_r;
    bitCntNext_s  = bitCnt_r;
    shiftNext_s   = shift_r;
    pushReq_s     = 1'b0;
    frameErr_s    = 1'b0;

    if ((state_r != IDLE) && !rxEn) begin
      // Disabling mid-frame abandons the partial byte.
      stateNext_s   = IDLE;
      divCntNext_s  = '0;
      tickCntNext_s = 4'd0;
      bitCntNext_s  = 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          // Hold the divider at zero so that it restarts at the start edge.
          divCntNext_s  = '0;
          tickCntNext_s = 4'd0;
          bitCntNext_s  = 3'd0;
          if (rxEn && !syncLine_r) begin
            stateNext_s = START;
          end else begin
            stateNext_s = IDLE;
          end
        end
        START: begin
          // Re-check the line at mid start bit to reject glitches.
          if (tick_s && (tickCnt_r == 4'd7)) begin
            tickCntNext_s = 4'd0;
            if (syncLine_r) begin
              stateNext_s = IDLE;
            end else begin
              stateNext_s = DATA;
            end
          end else begin
            stateNext_s = START;
          end
        end
        DATA: begin
          // Sample one bit every 16 ticks. Bits shift in from the MSB side.
          if (tick_s && (tickCnt_r == 4'd15)) begin
            shiftNext_s  = {syncLine_r, shift_r[7:1]};
            bitCntNext_s = bitCnt_r + 3'd1;
            if (bitCnt_r == 3'd7) begin
              stateNext_s = STOP;
            end else begin
              stateNext_s = DATA;
            end
          end else begin
            stateNext_s = DATA;
          end
        end
        STOP: begin
          if (tick_s && (tickCnt_r == 4'd15)) begin
            if (syncLine_r) begin
              pushReq_s   = 1'b1;
              stateNext_s = IDLE;
            end else begin
              frameErr_s  = 1'b1;
              stateNext_s = WAIT_IDLE;
            end
          end else begin
            stateNext_s = STOP;
          end
        end
        WAIT_IDLE: begin
          // A broken frame keeps the receiver busy until the line idles high again.
          divCntNext_s  = '0;
          tickCntNext_s = 4'd0;
          if (syncLine_r) begin
            stateNext_s = IDLE;
          end else begin
            stateNext_s = WAIT_IDLE;
          end
        end
        default: begin
          stateNext_s   = IDLE;
          divCntNext_s  = '0;
          tickCntNext_s = 4'd0;
          bitCntNext_s  = 3'd0;
        end
      endcase
    end
  end

  // Receiver registers. rxBusy and rxErr are registered copies of the next-state decisions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      divCnt_r  <= '0;
      tickCnt_r <= 4'd0;
      bitCnt_r  <= 3'd0;
      shift_r   <= 8'h00;
      rxBusy_r  <= 1'b0;
      rxErr_r   <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      divCnt_r  <= divCntNext_s;
      tickCnt_r <= tickCntNext_s;
      bitCnt_r  <= bitCntNext_s;
      shift_r   <= shiftNext_s;
      rxBusy_r  <= (stateNext_s != IDLE);
      rxErr_r   <= frameErr_s;
    end
  end

  // FIFO control: the push/pop decision, the pointer and count updates, the next head byte and the overflow flag.
  always_comb begin
    doPop_s     = rdEn & ~empty_r;
    doPush_s    = pushReq_s & (~full_r | doPop_s);
    ovfEvent_s  = pushReq_s & full_r & ~doPop_s;
    rdPtrNext_s = rdPtr_r + PTR_W'(doPop_s);
    wrPtrNext_s = wrPtr_r + PTR_W'(doPush_s);
    countNext_s = count_r + CNT_W'(doPush_s) - CNT_W'(doPop_s);

    // The incoming byte becomes the head when it lands where the read pointer will point.
    if (doPush_s && (wrPtr_r == rdPtrNext_s)) begin
      rdDataNext_s = shift_r;
    end else begin
      rdDataNext_s = mem_r[rdPtrNext_s];
    end

    // When an overflow and a clear occur in the same cycle, the overflow wins.
    if (ovfEvent_s) begin
      overflowNext_s = 1'b1;
    end else if (clrErr) begin
      overflowNext_s = 1'b0;
    end else begin
      overflowNext_s = overflow_r;
    end
  end

  // FIFO storage. The array is cleared on reset so that reads are deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (doPush_s) begin
      mem_r[wrPtr_r] <= shift_r;
    end
  end

  // FIFO pointers, occupancy flags, registered head byte and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_r    <= '0;
      rdPtr_r    <= '0;
      count_r    <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
      rdData_r   <= 8'h00;
    end else begin
      wrPtr_r    <= wrPtrNext_s;
      rdPtr_r    <= rdPtrNext_s;
      count_r    <= countNext_s;
      empty_r    <= (countNext_s == '0);
      full_r     <= (countNext_s == DEPTH_C);
      overflow_r <= overflowNext_s;
      rdData_r   <= rdDataNext_s;
    end
  end

  assign rxBusy   = rxBusy_r;
  assign rxErr    = rxErr_r;
  assign rdData   = rdData_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_uart8_rx_fifo.sv
// tb_uart8_rx_fifo: directed bench for uart8_rx_fifo.
// It uses a fast bit rate of 64 clocks per bit, with an oversample divider of 4.
module tb_uart8_rx_fifo;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       reset;
  logic       rxEn;
  logic       rxIn;
  logic       rxBusy;
  logic       rxErr;
  logic       rdEn;
  logic [7:0] rdData;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       clrErr;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  int errCnt = 0;
  int busyCycles = 0;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         pops;
    int         expCount;
    logic [7:0] expHead;
    int         expErr;
    logic       expOvf;
    int         expCountAfter;
  } vec_t;

  vec_t vecs[12];
  vec_t v;
  logic [7:0] expSeq[20];
  logic [7:0] got[$];
  logic readerOn;

  uart8_rx_fifo #(
    .CLOCK_RATE(6400000),
    .BAUD_RATE(100000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rxEn(rxEn),
    .rxIn(rxIn),
    .rxBusy(rxBusy),
    .rxErr(rxErr),
    .rdEn(rdEn),
    .rdData(rdData),
    .empty(empty),
    .full(full),
    .count(count),
    .clrErr(clrErr),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count the cycles in which the DUT asserts rxErr and rxBusy.
  always @(negedge clk) begin
    if (rxErr === 1'b1) errCnt++;
    if (rxBusy === 1'b1) busyCycles++;
  end

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive start, eight data bits (LSB first) and a stop bit. The line is left at the stop bit value.
  task automatic sendBits(input logic [7:0] d, input logic stopBit);
    logic [9:0] f;
    f = {stopBit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxIn = f[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit);
    sendBits(d, stopBit);
    rxIn = 1'b1;
  endtask

  task automatic popOne();
    rdEn = 1'b1;
    @(posedge clk);
    #1;
    rdEn = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rxEn = 1'b1; rxIn = 1'b1; rdEn = 1'b0; clrErr = 1'b0;
    readerOn = 1'b0;

    vecs[0] = '{8'h1E, 1'b1, 1, 1, 8'h1E, 0, 1'b0, 0};
    vecs[1] = '{8'hA5, 1'b0, 0, 0, 8'h00, 1, 1'b0, 0};
    vecs[2] = '{8'h3C, 1'b1, 1, 1, 8'h3C, 0, 1'b0, 0};
    for (int k = 0; k < 9; k++) begin
      vecs[3+k] = '{8'(k + 1), 1'b1, 0, (k < 8) ? k + 1 : 8, 8'h01, 0, (k == 8), (k < 8) ? k + 1 : 8};
    end
    expSeq = '{8'd30, 8'd24, 8'd19, 8'd25, 8'd91, 8'd77, 8'd1, 8'd0, 8'd99, 8'd15,
               8'd100, 8'd128, 8'd255, 8'd254, 8'd0, 8'd10, 8'd43, 8'd149, 8'd7, 8'd2};

    // Reset values
    waitCycles(4);
    check("rst_rxBusy", rxBusy, 0);
    check("rst_rxErr", rxErr, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rdData", rdData, 8'h00);
    reset = 1'b1;
    waitCycles(4);

    // Table-driven frames
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      errCnt = 0;
      busyCycles = 0;
      sendFrame(v.data, v.stopBit);
      waitCycles(6);
      check($sformatf("vec%0d_count", i), count, v.expCount);
      check($sformatf("vec%0d_empty", i), empty, (v.expCount == 0));
      check($sformatf("vec%0d_full", i), full, (v.expCount == 8));
      check($sformatf("vec%0d_rxErr", i), errCnt, v.expErr);
      check($sformatf("vec%0d_overflow", i), overflow, v.expOvf);
      check($sformatf("vec%0d_rxBusy", i), rxBusy, 0);
      check($sformatf("vec%0d_busyLen", i), (busyCycles >= 560 && busyCycles <= 660), 1);
      if (v.expCount != 0) check($sformatf("vec%0d_rdData", i), rdData, v.expHead);
      for (int p = 0; p < v.pops; p++) popOne();
      check($sformatf("vec%0d_countAfter", i), count, v.expCountAfter);
    end

    // Drain the full FIFO, then clear the overflow flag
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d_rdData", k), rdData, k + 1);
      popOne();
    end
    check("drain_empty", empty, 1);
    check("drain_overflowSticky", overflow, 1);
    clrErr = 1'b1;
    waitCycles(1);
    clrErr = 1'b0;
    check("clrErr_overflow", overflow, 0);

    // Glitch of 4 ticks (16 clocks) on the idle line
    errCnt = 0;
    rxIn = 1'b0;
    waitCycles(16);
    rxIn = 1'b1;
    check("glitch_busyHigh", rxBusy, 1);
    waitCycles(23);
    check("glitch_busyLow", rxBusy, 0);
    waitCycles(10);
    check("glitch_count", count, 0);
    check("glitch_rxErr", errCnt, 0);

    // Framing error with the line held low after the stop bit
    errCnt = 0;
    sendBits(8'hA5, 1'b0);
    waitCycles(60);
    check("ferr_busyHeld", rxBusy, 1);
    check("ferr_rxErrPulse", errCnt, 1);
    check("ferr_count", count, 0);
    rxIn = 1'b1;
    waitCycles(5);
    check("ferr_busyRelease", rxBusy, 0);
    sendFrame(8'h3C, 1'b1);
    waitCycles(6);
    check("ferr_next_count", count, 1);
    check("ferr_next_rdData", rdData, 8'h3C);
    check("ferr_next_rxErr", errCnt, 1);
    popOne();

    // 20 back-to-back frames with a reader that pops whenever the FIFO is non-empty
    errCnt = 0;
    got.delete();
    readerOn = 1'b1;
    fork
      begin
        for (int k = 0; k < 20; k++) sendFrame(expSeq[k], 1'b1);
        waitCycles(10);
        readerOn = 1'b0;
      end
      begin
        while (readerOn) begin
          @(negedge clk);
          if (empty === 1'b0) begin
            got.push_back(rdData);
            rdEn = 1'b1;
          end else begin
            rdEn = 1'b0;
          end
        end
        rdEn = 1'b0;
      end
    join
    check("b2b_numRead", got.size(), 20);
    for (int k = 0; k < 20; k++) begin
      if (k < got.size()) check($sformatf("b2b%0d_data", k), got[k], expSeq[k]);
      else check($sformatf("b2b%0d_missing", k), 1, 0);
    end
    check("b2b_rxErr", errCnt, 0);
    check("b2b_overflow", overflow, 0);
    check("b2b_empty", empty, 1);

    // Reset during bit 4 of a frame, with 2 bytes stored
    sendFrame(8'h11, 1'b1);
    sendFrame(8'h22, 1'b1);
    waitCycles(6);
    check("rstmid_preCount", count, 2);
    check("rstmid_preHead", rdData, 8'h11);
    fork
      sendFrame(8'hF0, 1'b1);
      begin
        waitCycles(BIT_CLKS * 5 + 30);
        check("rstmid_busyBefore", rxBusy, 1);
        reset = 1'b0;
        #2;
        check("rstmid_count", count, 0);
        check("rstmid_rxBusy", rxBusy, 0);
        check("rstmid_empty", empty, 1);
        waitCycles(2);
        reset = 1'b1;
      end
    join
    waitCycles(10);
    check("rstmid_lostFrame", count, 0);
    check("rstmid_idle", rxBusy, 0);
    sendFrame(8'h55, 1'b1);
    waitCycles(6);
    check("rstmid_next_count", count, 1);
    check("rstmid_next_rdData", rdData, 8'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart8_rx_fifo.md
UART8_RX_FIFO -- requirements
Module: uart8_rx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, received-byte buffer entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rxEn  input  1  receiver enable.
REQ-007 SHALL have port rxIn  input  1  asynchronous serial line, 8N1, idle high.
REQ-008 SHALL have port rxBusy  output  1  high while a frame is being received.
REQ-009 SHALL have port rxErr  output  1  one-cycle pulse on framing error.
REQ-010 SHALL have port rdEn  input  1  pop request from reader.
REQ-011 SHALL have port rdData  output  8  head-of-FIFO byte (show-ahead).
REQ-012 SHALL have port empty  output  1  FIFO holds no bytes.
REQ-013 SHALL have port full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-014 SHALL have port count  output  $clog2(FIFO_DEPTH+1)  bytes held.
REQ-015 SHALL have port clrErr  input  1  clears overflow.
REQ-016 SHALL have port overflow  output  1  sticky: a received byte was dropped.

Function
REQ-017 SHALL pass rxIn through a 2-flop synchronizer; both flops reset to 1.
REQ-018 SHALL generate a 16x oversample tick every CLOCK_RATE/(BAUD_RATE*16) clocks (integer division; 78 at defaults); the divider restarts on start-bit detection.
REQ-019 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-020 IDLE: when rxEn=1 and synced line=0, SHALL go to START and raise rxBusy the next cycle.
REQ-021 START: at tick 8, line=1 SHALL be treated as a false start (back to IDLE, rxBusy low, no error); line=0 SHALL go to DATA.
REQ-022 DATA: SHALL sample 8 bits LSB first, each 16 ticks after the previous sample.
REQ-023 STOP: 16 ticks after bit 7, line=1 SHALL push the byte and return to IDLE; line=0 SHALL pulse rxErr for one cycle, discard the byte, and go to WAIT_IDLE.
REQ-024 WAIT_IDLE: SHALL hold rxBusy high until the synced line is 1, then go to IDLE.
REQ-025 The push SHALL update count/empty/rdData on the clock after the stop-bit sample cycle.
REQ-026 rxEn=0 in any non-IDLE state SHALL abort to IDLE on the next clock, discard the partial byte, drop rxBusy; FIFO contents SHALL be unaffected.
REQ-027 rdData SHALL equal the oldest stored byte whenever empty=0; it is don't-care when empty=1.
REQ-028 rdEn=1 with empty=0 SHALL pop one byte per cycle; rdEn=1 with empty=1 SHALL be ignored.
REQ-029 A push while full with no pop SHALL drop the new byte and set overflow; stored data SHALL be unchanged.
REQ-030 Simultaneous push and pop when full SHALL both occur; count SHALL stay FIFO_DEPTH; overflow SHALL not be set.
REQ-031 Simultaneous push and pop when empty SHALL perform only the push (count 0->1).
REQ-032 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL derive from count.
REQ-033 clrErr=1 SHALL clear overflow; if an overflow occurs in the same cycle, overflow SHALL stay set.

Reset
REQ-034 reset=0 SHALL asynchronously force: state IDLE, rxBusy 0, rxErr 0, count 0, empty 1, full 0, overflow 0, pointers 0, synchronizer 1, divider 0; rdData SHALL be 0.
REQ-035 Deassertion mid-frame SHALL resume in IDLE; the interrupted frame is lost; reception SHALL restart on the next falling edge.

Verification
REQ-036 Defaults, single frame 0x1E at 9600 baud -> rxBusy for ~10 bit times, then empty=0, count=1, rdData=0x1E; one rdEn -> empty=1.
REQ-037 20 back-to-back frames 30,24,19,25,91,77,1,0,99,15,100,128,255,254,0,10,43,149,7,2 with reader popping whenever empty=0 -> identical 20-byte sequence read, rxErr never pulses, overflow=0.
REQ-038 Frame 0xA5 with stop bit driven 0 -> one-cycle rxErr, count unchanged, rxBusy held until the line returns high; next valid frame 0x3C received correctly.
REQ-039 Low glitch of 4 oversample ticks on idle line -> no push, no rxErr, rxBusy returns low within 9 ticks.
REQ-040 9 frames 0x01..0x09 with no reads -> full=1, count=8, overflow=1; reads return 0x01..0x08; clrErr -> overflow=0.
REQ-041 reset=0 pulsed during bit 4 of a frame, with 2 bytes stored -> immediately count=0, rxBusy=0; next frame 0x55 -> count=1, rdData=0x55.
